hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers by generating their stall and flush controls, and generates the EX-stage operand forwarding selects.
- Keeps its own shadow scoreboard of the destination register, RegWrite and load flags for the EX, MEM and WB stages, so hazards are resolved from internally tracked state.
- Keeps two saturating performance counters (stalls, flushes).

---
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush sequencing,
// EX operand forwarding selects, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1_D,
    input  logic [REG_ADDR_W-1:0] Rs2_D,
    input  logic [REG_ADDR_W-1:0] Rd_D,
    input  logic                  RegWrite_D,
    input  logic [1:0]            ResultSrc_D,
    input  logic                  PCSrc_E,
    input  logic                  MemStall,
    output logic                  Stall_F,
    output logic                  Stall_D,
    output logic                  Flush_D,
    output logic                  Stall_E,
    output logic                  Flush_E,
    output logic                  Stall_M,
    output logic                  Stall_W,
    output logic [1:0]            ForwardA_E,
    output logic [1:0]            ForwardB_E,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Shadow scoreboard: _p0 = EX slot, _p1 = MEM slot, _p2 = WB slot
    logic [REG_ADDR_W-1:0] rd_p0, rs1_p0, rs2_p0, rd_p1, rd_p2;
    logic                  rw_p0, ld_p0, rw_p1, rw_p2;
    logic                  lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic [REG_ADDR_W-1:0] m_rd,
                                           input logic                  m_rw,
                                           input logic [REG_ADDR_W-1:0] w_rd,
                                           input logic                  w_rw);
        if (m_rw && (m_rd != '0) && (m_rd == rs))
            return 2'b10;
        else if (w_rw && (w_rd != '0) && (w_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lu = ld_p0 && rw_p0 && (rd_p0 != '0) &&
                ((rd_p0 == Rs1_D) || (rd_p0 == Rs2_D));

    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Flush_D = 1'b0;
        Stall_E = 1'b0;
        Flush_E = 1'b0;
        Stall_M = 1'b0;
        Stall_W = 1'b0;
        if (MemStall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Stall_W = 1'b1;
        end else if (PCSrc_E) begin
            // A taken branch squashes the dependent instruction, so no load-use stall
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (lu) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    assign ForwardA_E = fwd_sel(rs1_p0, rd_p1, rw_p1, rd_p2, rw_p2);
    assign ForwardB_E = fwd_sel(rs2_p0, rd_p1, rw_p1, rd_p2, rw_p2);

    // Stage advance: whole scoreboard freezes while data memory is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_p0     <= '0;
            rw_p0     <= 1'b0;
            ld_p0     <= 1'b0;
            rs1_p0    <= '0;
            rs2_p0    <= '0;
            rd_p1     <= '0;
            rw_p1     <= 1'b0;
            rd_p2     <= '0;
            rw_p2     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!MemStall) begin
            rd_p2 <= rd_p1;
            rw_p2 <= rw_p1;
            rd_p1 <= rd_p0;
            rw_p1 <= rw_p0;
            if (Flush_E) begin
                rd_p0  <= '0;
                rw_p0  <= 1'b0;
                ld_p0  <= 1'b0;
                rs1_p0 <= '0;
                rs2_p0 <= '0;
            end else begin
                rd_p0  <= Rd_D;
                rw_p0  <= RegWrite_D;
                ld_p0  <= (ResultSrc_D == 2'b01);
                rs1_p0 <= Rs1_D;
                rs2_p0 <= Rs2_D;
            end
            if (Stall_D)
                stall_cnt <= sat_inc(stall_cnt);
            if (Flush_D || Flush_E)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle comparison against an
// instruction-slot model plus directed literal checks of the test scenarios.
module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;

    logic          clk, rst_n;
    logic [AW-1:0] Rs1_D, Rs2_D, Rd_D;
    logic          RegWrite_D, PCSrc_E, MemStall;
    logic [1:0]    ResultSrc_D;
    logic          Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Stall_W;
    logic [1:0]    ForwardA_E, ForwardB_E;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    ctrl;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D),
        .PCSrc_E(PCSrc_E), .MemStall(MemStall),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
        .Stall_E(Stall_E), .Flush_E(Flush_E), .Stall_M(Stall_M), .Stall_W(Stall_W),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Stall_W}
    assign ctrl = {Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Stall_W};

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_MEM  = 7'b1101011;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_LU   = 7'b1100100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one record per in-flight instruction in EX, MEM, WB
    typedef struct packed {
        logic [AW-1:0] rd;
        logic          rw;
        logic          ld;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
    } slot_t;

    slot_t me, mm, mw;
    int    msc, mfc;

    function automatic logic m_lu();
        return me.ld && me.rw && (me.rd != 0) && ((me.rd == Rs1_D) || (me.rd == Rs2_D));
    endfunction

    function automatic logic [6:0] m_ctrl();
        if (MemStall)     return C_MEM;
        else if (PCSrc_E) return C_BR;
        else if (m_lu())  return C_LU;
        else              return C_NONE;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
        if (mm.rw && mm.rd != 0 && mm.rd == src)      return 2'b10;
        else if (mw.rw && mw.rd != 0 && mw.rd == src) return 2'b01;
        else                                          return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            me = '0; mm = '0; mw = '0; msc = 0; mfc = 0;
        end else if (!MemStall) begin
            if (!PCSrc_E && m_lu() && msc < MAX) msc = msc + 1;
            if ((PCSrc_E || m_lu()) && mfc < MAX) mfc = mfc + 1;
            mw = mm;
            mm = me;
            if (PCSrc_E || m_lu()) me = '0;
            else me = '{rd: Rd_D, rw: RegWrite_D, ld: (ResultSrc_D == 2'b01),
                        rs1: Rs1_D, rs2: Rs2_D};
        end
    end

    always @(negedge clk) begin
        chk("ctrl", int'(ctrl), int'(m_ctrl()));
        chk("fwdA", int'(ForwardA_E), int'(m_fwd(me.rs1)));
        chk("fwdB", int'(ForwardB_E), int'(m_fwd(me.rs2)));
        chk("stall_cnt", int'(stall_cnt), msc);
        chk("flush_cnt", int'(flush_cnt), mfc);
    end

    task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic rw,
                         input logic [1:0] src, input logic pcs, input logic ms);
        @(posedge clk);
        #1;
        Rs1_D = rs1; Rs2_D = rs2; Rd_D = rd; RegWrite_D = rw;
        ResultSrc_D = src; PCSrc_E = pcs; MemStall = ms;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        Rs1_D = '0; Rs2_D = '0; Rd_D = '0; RegWrite_D = 1'b0;
        ResultSrc_D = 2'b00; PCSrc_E = 1'b0; MemStall = 1'b0;
        #3;
        chk("rst_ctrl", int'(ctrl), 0);
        chk("rst_cnt", int'({stall_cnt, flush_cnt}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        nop();
        chk("idle_ctrl", int'(ctrl), 0);
        chk("idle_fwd", int'({ForwardA_E, ForwardB_E}), 0);

        // add x5,x1,x2 ; sub x6,x5,x3 ; and x8,x4,x5
        drive(1, 2, 5, 1'b1, 2'b00, 1'b0, 1'b0);
        drive(5, 3, 6, 1'b1, 2'b00, 1'b0, 1'b0);
        drive(4, 5, 8, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("fwd_mem_A", int'(ForwardA_E), 2'b10);
        chk("fwd_nostall", int'(ctrl), 0);
        nop();
        chk("fwd_wb_B", int'(ForwardB_E), 2'b01);
        chk("fwd_wb_A", int'(ForwardA_E), 2'b00);
        nop(); nop();

        // lw x7 ; use x7 -> one bubble
        drive(1, 0, 7, 1'b1, 2'b01, 1'b0, 1'b0);
        drive(7, 0, 9, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("lu_ctrl", int'(ctrl), int'(C_LU));
        drive(7, 0, 9, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("lu_after", int'(ctrl), 0);
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        chk("lu_flush_cnt", int'(flush_cnt), 1);
        nop();
        chk("lu_fwdA_wb", int'(ForwardA_E), 2'b01);
        nop(); nop();

        // lw x7 ; use x7 with taken branch in the same cycle
        drive(1, 0, 7, 1'b1, 2'b01, 1'b0, 1'b0);
        drive(7, 0, 9, 1'b1, 2'b00, 1'b1, 1'b0);
        chk("br_ctrl", int'(ctrl), int'(C_BR));
        nop();
        chk("br_stall_cnt", int'(stall_cnt), 1);
        chk("br_flush_cnt", int'(flush_cnt), 2);

        // lw x7 ; use x7 while data memory stalls for 3 cycles
        drive(1, 0, 7, 1'b1, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 7, 9, 1'b1, 2'b00, 1'b0, 1'b1);
            chk("ms_ctrl", int'(ctrl), int'(C_MEM));
            chk("ms_cnt", int'({stall_cnt, flush_cnt}), int'({8'd1, 8'd2}));
        end
        drive(0, 7, 9, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("ms_lu_ctrl", int'(ctrl), int'(C_LU));
        nop();
        chk("ms_cnt_after", int'({stall_cnt, flush_cnt}), int'({8'd2, 8'd3}));
        nop(); nop();

        // load into x0 followed by reader of x0
        drive(1, 0, 0, 1'b1, 2'b01, 1'b0, 1'b0);
        drive(0, 0, 8, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("x0_ctrl", int'(ctrl), 0);
        nop();
        chk("x0_fwd_m", int'({ForwardA_E, ForwardB_E}), 0);
        nop();
        chk("x0_fwd_w", int'({ForwardA_E, ForwardB_E}), 0);

        // repeated load-use pairs saturate both counters
        for (int i = 0; i < MAX + 5; i++) begin
            drive(1, 0, 7, 1'b1, 2'b01, 1'b0, 1'b0);
            drive(7, 7, 9, 1'b1, 2'b00, 1'b0, 1'b0);
        end
        nop();
        chk("sat_stall", int'(stall_cnt), MAX);
        chk("sat_flush", int'(flush_cnt), MAX);

        // asynchronous reset in the middle of a load-use stall
        drive(1, 0, 7, 1'b1, 2'b01, 1'b0, 1'b0);
        drive(7, 0, 9, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("pre_rst_stall", int'(Stall_D), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", int'(ctrl), 0);
        chk("arst_fwd", int'({ForwardA_E, ForwardB_E}), 0);
        chk("arst_cnt", int'({stall_cnt, flush_cnt}), 0);
        nop();
        rst_n = 1'b1;
        nop();
        chk("post_rst", int'(ctrl), 0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
